// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: FSM state type and round-robin winner selection shared by the SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int MAX_MASTERS = 8;
  // Scan descending so the smallest offset from last_id+1 is written last and wins.
  function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] last_id, input int n);
    logic [2:0] w;
    int idx;
    w = last_id;
    for (int k = MAX_MASTERS; k >= 1; k--)
      if (k <= n) begin
        idx = (int'(last_id) + k) % n;
        if (req[idx[2:0]]) w = idx[2:0];
      end
    return w;
  endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: master-id FIFO tracking outstanding reads; ports clk/rst, push/din, pop, full/empty/head.
module sdram_arb_tag_fifo #(
  parameter int W = 1,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // Depth is a power of two, so the count MSB alone marks full.
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign head = mem[rp];
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin share of one SDRAM Avalon slave among NUM_MASTERS masters; m_* per-master ports, s_* controller port, read tags route returns.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               s_address,
  output logic                            s_read,
  output logic                            s_write,
  output logic [DATA_W-1:0]               s_writedata,
  output logic [DATA_W/8-1:0]             s_byteenable,
  input  logic                            s_waitrequest,
  input  logic [DATA_W-1:0]               s_readdata,
  input  logic                            s_readdatavalid,
  output logic                            err_unexpected_rdv
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int BW = DATA_W / 8;
  state_t state, state_nx;
  logic [IW-1:0] gnt_id, last_id, gnt_nx, head;
  logic [NUM_MASTERS-1:0] req, gnt_oh, head_oh;
  logic rd, wr, full, empty, accept, pop, in_gnt;
  assign req = m_read | m_write;
  assign in_gnt = state == GRANT;
  assign rd = m_read[gnt_id];
  assign wr = m_write[gnt_id];
  // A full tag FIFO blocks the read; full is registered so a same-cycle pop cannot unblock it.
  assign s_read = in_gnt && rd && !full;
  assign s_write = in_gnt && wr && !rd;
  assign accept = (s_read || s_write) && !s_waitrequest;
  assign s_address = in_gnt ? m_address[gnt_id*ADDR_W +: ADDR_W] : '0;
  assign s_writedata = in_gnt ? m_writedata[gnt_id*DATA_W +: DATA_W] : '0;
  assign s_byteenable = in_gnt ? m_byteenable[gnt_id*BW +: BW] : '0;
  assign gnt_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gnt_id;
  assign head_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << head;
  assign m_waitrequest = accept ? ~gnt_oh : '1;
  assign pop = s_readdatavalid && !empty;
  assign m_readdatavalid = pop ? head_oh : '0;
  assign m_readdata = s_readdata;
  assign gnt_nx = IW'(next_rr(8'(req), 3'(last_id), NUM_MASTERS));
  // A master dropping its request mid-grant sends the FSM back to IDLE without issuing.
  always_comb
    state_nx = state == IDLE ? (|req ? GRANT : IDLE) : (accept || !(rd || wr)) ? IDLE : GRANT;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state <= IDLE;
      gnt_id <= '0;
      last_id <= IW'(NUM_MASTERS - 1);
      err_unexpected_rdv <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) gnt_id <= gnt_nx;
      if (accept) last_id <= gnt_id;
      if (s_readdatavalid && empty) err_unexpected_rdv <= 1'b1;
    end
  sdram_arb_tag_fifo #(.W(IW), .D(MAX_PENDING)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push(accept && s_read),
    .pop(pop),
    .din(gnt_id),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
